pwm_av_out: RTL

PWM_AV_OUT -- requirements
Module: pwm_av_out

---
 rtl/pwm_av_pkg.sv | 21 ++
 rtl/pwm_av_core.sv | 59 +++++
 rtl/pwm_av_out.sv | 90 +++++++++
 3 files changed

// File: rtl/pwm_av_pkg.sv
// Shared register map and control-bit layout for the Avalon-MM PWM peripheral.
package pwm_av_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_DUTY   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_INV_BIT     = 1;
   localparam int CTRL_IE_BIT      = 2;
   localparam int STATUS_DONE_BIT  = 0;
   localparam int STATUS_COUNT_LSB = 16;

   typedef struct packed {
      logic ie;
      logic inv;
      logic en;
   } ctrl_t;

endpackage

// File: rtl/pwm_av_core.sv
// PWM engine: active period/duty copies, free-running counter and registered compare output.
module pwm_av_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             inv,
   input  logic [WIDTH-1:0] period_load,
   input  logic [WIDTH-1:0] duty_load,
   output logic [WIDTH-1:0] counter,
   output logic             wrap,
   output logic             pwm_out
);

   logic             running;
   logic [WIDTH-1:0] period_act;
   logic [WIDTH-1:0] duty_act;
   logic             start;
   logic             active;

   // running remembers en from the previous edge, so start marks the 0->1 transition
   assign start  = en & ~running;
   assign active = en & running & (period_act != '0);
   assign wrap   = active & (counter == period_act - WIDTH'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         running    <= 1'b0;
         period_act <= '0;
         duty_act   <= '0;
         counter    <= '0;
         pwm_out    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         running <= en;
         pwm_out <= inv;
         if (!en) begin
            counter <= '0;
         end else if (start) begin
            period_act <= period_load;
            duty_act   <= duty_load;
            counter    <= '0;
         end else if (active) begin
            pwm_out <= (counter < duty_act) ^ inv;
            if (wrap) begin
               counter    <= '0;
               period_act <= period_load;
               duty_act   <= duty_load;
            end else begin
               counter <= counter + WIDTH'(1);
            end
         end else begin
            counter <= '0;
         end
      end
   end

endmodule

// File: rtl/pwm_av_out.sv
// Avalon-MM PWM peripheral: register file, sticky done/irq and registered read mux around pwm_av_core.
module pwm_av_out
   import pwm_av_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic        read,
   output logic [31:0] readdata,
   output logic        pwm_out,
   output logic        irq
);

   ctrl_t            ctrl;
   logic [WIDTH-1:0] period_stage;
   logic [WIDTH-1:0] duty_stage;
   logic [WIDTH-1:0] period_next;
   logic [WIDTH-1:0] duty_next;
   logic [WIDTH-1:0] counter;
   logic             done;
   logic             done_clear;
   logic             wrap;
   logic [31:0]      rd_value;
   logic             unused_wdata;

   assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
   assign done_clear   = write && (address == ADDR_STATUS) && writedata[STATUS_DONE_BIT];
   assign irq          = done & ctrl.ie;

   // The core loads the post-write staging values so a write on the wrap edge lands in the new cycle
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      period_next = period_stage;
      duty_next   = duty_stage;
      if (write && (address == ADDR_PERIOD)) period_next = writedata[WIDTH-1:0];
      if (write && (address == ADDR_DUTY))   duty_next   = writedata[WIDTH-1:0];
   end

   always_comb begin
      rd_value = '0;
      case (address)
         ADDR_CTRL: begin
            rd_value[CTRL_EN_BIT]  = ctrl.en;
            rd_value[CTRL_INV_BIT] = ctrl.inv;
            rd_value[CTRL_IE_BIT]  = ctrl.ie;
         end
         ADDR_PERIOD: rd_value = 32'(period_stage);
         ADDR_DUTY:   rd_value = 32'(duty_stage);
         default:     rd_value = (32'(counter) << STATUS_COUNT_LSB) | 32'(done);
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl         <= '0;
         period_stage <= '0;
         duty_stage   <= '0;
         done         <= 1'b0;
         readdata     <= '0;
      end else begin
         period_stage <= period_next;
         duty_stage   <= duty_next;
         if (write && (address == ADDR_CTRL)) begin
            ctrl <= '{ie:  writedata[CTRL_IE_BIT],
                      inv: writedata[CTRL_INV_BIT],
                      en:  writedata[CTRL_EN_BIT]};
         end
         if (wrap)            done <= 1'b1;
         else if (done_clear) done <= 1'b0;
         if (read) readdata <= rd_value;
      end
   end

   pwm_av_core #(.WIDTH(WIDTH)) u_core (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (ctrl.en),
      .inv         (ctrl.inv),
      .period_load (period_next),
      .duty_load   (duty_next),
      .counter     (counter),
      .wrap        (wrap),
      .pwm_out     (pwm_out)
   );

endmodule
